// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) responder, MSB first.
// sck/ss_n/mosi are oversampled in the clk domain; TX bytes enter through a
// one-entry valid/ready buffer, RX bytes leave as a one-cycle strobe.
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN (miso floats while deselected).
module spi_slave #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sck,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_tx_underrun,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_hist;
  logic                   r_ss_hist;

  logic w_sck_s;
  logic w_ss_s;
  logic w_mosi_s;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ss_fall;

  // FSM and datapath
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_rx_shift;
  logic [DATA_W-1:0]  r_tx_shift;
  logic [DATA_W-1:0]  r_tx_buf;
  logic               r_tx_ready;
  logic               r_tx_underrun;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_rx_valid;
  logic               r_busy;
  logic               r_miso;

  logic w_load;
  logic w_shift_rise;
  logic w_shift_fall;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_hist;
  assign w_sck_fall = ~w_sck_s & r_sck_hist;
  assign w_ss_fall  = ~w_ss_s & r_ss_hist;

  // Bring the asynchronous pins into the clk domain; ss_n idles deasserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_hist  <= 1'b0;
      r_ss_hist   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_hist  <= w_sck_s;
      r_ss_hist   <= w_ss_s;
    end
  end

  // Next-state logic; a deasserted ss_n returns to IDLE from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = ST_SHIFT;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_ss_s) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Datapath strobes. Abort outranks a coincident sck edge, so a master that
  // drops sck and raises ss_n together ends the frame without a spare load.
  always_comb begin
    w_load       = 1'b0;
    w_shift_rise = 1'b0;
    w_shift_fall = 1'b0;
    if (w_ss_s) begin
      w_load = 1'b0;
    end else if (r_state == ST_LOAD) begin
      w_load = 1'b1;
    end else if (r_state == ST_SHIFT) begin
      if (w_sck_rise) begin
        w_shift_rise = 1'b1;
      end else if (w_sck_fall) begin
        if (r_bit_cnt == CNT_W'(DATA_W)) begin
          w_load = 1'b1;
        end else begin
          w_shift_fall = 1'b1;
        end
      end else begin
        w_shift_rise = 1'b0;
      end
    end else begin
      w_load = 1'b0;
    end
  end

  // State register with registered busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Shift registers, bit counter, miso and RX strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_miso        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (w_state_nxt == ST_IDLE) begin
        // idle or aborting: partial RX and the in-flight TX byte are dropped
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= '0;
        r_miso     <= 1'b0;
      end else if (w_load) begin
        r_bit_cnt <= '0;
        if (!r_tx_ready) begin
          r_tx_shift <= r_tx_buf;
          r_miso     <= r_tx_buf[DATA_W-1];
        end else begin
          r_tx_shift    <= DEFAULT_TX;
          r_miso        <= DEFAULT_TX[DATA_W-1];
          r_tx_underrun <= 1'b1;
        end
      end else if (w_shift_fall) begin
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        r_miso     <= r_tx_shift[DATA_W-2];
      end else if (w_shift_rise) begin
        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          r_rx_data  <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_valid <= 1'b0;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

  // One-entry TX buffer. A load sees the pre-cycle fill state, so a byte
  // offered during a load from an empty buffer is kept for the next load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_load && !r_tx_ready) begin
        r_tx_ready <= 1'b1;
      end else if (i_tx_valid && r_tx_ready) begin
        r_tx_buf   <= i_tx_data;
        r_tx_ready <= 1'b0;
      end else begin
        r_tx_ready <= r_tx_ready;
      end
    end
  end

  assign o_tx_ready    = r_tx_ready;
  assign o_tx_underrun = r_tx_underrun;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_busy        = r_busy;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_miso = (w_ss_s || (r_state == ST_IDLE)) ? 1'bz : r_miso;
`else
  assign o_miso = r_miso;
`endif

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// tb_spi_slave: self-checking bench for spi_slave (table vectors, hand-written
// corner sequences, randomized frames against a FIFO-level reference model).
module tb_spi_slave;

  localparam int         HALF   = 8;      // sck half period in clk cycles
  localparam logic [7:0] DEF_TX = 8'h00;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sck    = 1'b0;
  logic       ss_n   = 1'b1;
  logic       mosi   = 1'b0;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  // TX side is driven either by the feeder process or manually by the test
  logic       feed_en  = 1'b0;
  logic       f_valid  = 1'b0;
  logic [7:0] f_data   = 8'h00;
  logic       m_valid  = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic       hs_ready = 1'b0;
  assign tx_valid = feed_en ? f_valid : m_valid;
  assign tx_data  = feed_en ? f_data  : m_data;

  int  n_total   = 0;
  int  n_pass    = 0;
  int  underruns = 0;
  bq_t rx_seen;
  bq_t tx_q;
  bq_t model_q;

  spi_slave dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sck        (sck),
    .i_ss_n       (ss_n),
    .i_mosi       (mosi),
    .o_miso       (miso),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_tx_underrun(tx_underrun),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Record every received-byte strobe cycle and every underrun cycle.
  always @(negedge clk) begin
    if (rx_valid) rx_seen.push_back(rx_data);
    if (tx_underrun) underruns++;
  end

  // Stream tx_q into the DUT buffer over valid/ready.
  always @(negedge clk) begin
    if (feed_en) begin
      if (f_valid && hs_ready && tx_q.size() > 0) void'(tx_q.pop_front());
      hs_ready = tx_ready;
      if (tx_q.size() > 0) begin
        f_valid = 1'b1;
        f_data  = tx_q[0];
      end else begin
        f_valid = 1'b0;
      end
    end
  end

  // Global time limit.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d compared ok", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] q_at(input bq_t q, input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: one ss_n frame; the final byte may stop after last_bits.
  // sck falls and ss_n rises together at the end of the frame.
  task automatic spi_frame(input bq_t mo, input int last_bits, output bq_t mi);
    logic [7:0] r;
    int nb;
    mi = {};
    ss_n = 1'b0;
    for (int i = 0; i < mo.size(); i++) begin
      nb = (i == mo.size() - 1) ? last_bits : 8;
      r = 8'h00;
      for (int b = 0; b < nb; b++) begin
        mosi = mo[i][7-b];
        wait_clks(HALF);
        r[7-b] = miso;
        sck = 1'b1;
        wait_clks(HALF);
        sck = 1'b0;
        if (i == mo.size() - 1 && b == nb - 1) ss_n = 1'b1;
      end
      mi.push_back(r);
    end
    mosi = 1'b0;
    wait_clks(2 * HALF);
  endtask

  task automatic load_buf(input logic [7:0] d);
    m_data  = d;
    m_valid = 1'b1;
    wait_clks(1);
    m_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    bq_t  mo;
    bq_t  mi;
    int   n, k, last_bits, exp_ur;
    logic abort_f;
    logic [7:0] e, b;
    bit   seen_busy;

    vecs[0] = '{tx: 8'hA5, mo: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{tx: 8'hFF, mo: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00};
    vecs[2] = '{tx: 8'h00, mo: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
    vecs[3] = '{tx: 8'h81, mo: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};
    vecs[4] = '{tx: 8'h5A, mo: 8'hA5, exp_miso: 8'h5A, exp_rx: 8'hA5};

    // ---- reset state ----
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(1);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_underrun", {31'b0, tx_underrun}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_miso", {31'b0, miso}, {31'b0, IDLE_MISO});

    // ---- reset mid-transfer at a random phase, buffered byte dropped ----
    load_buf(8'h77);
    check("buf_full_ready", {31'b0, tx_ready}, 32'd0);
    fork
      begin
        ss_n = 1'b0;
        for (int h = 0; h < 16; h++) begin
          mosi = 1'($urandom_range(0, 1));
          wait_clks(HALF);
          sck = ~sck;
        end
      end
      begin
        #($urandom_range(300, 1100));
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("arst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("arst_rx_data", {24'b0, rx_data}, 32'd0);
      end
    join
    sck  = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(1);
    check("post_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    rx_seen.delete();
    underruns = 0;
    mo = {8'h12};
    spi_frame(mo, 8, mi);
    check("post_rst_miso_default", {24'b0, q_at(mi, 0)}, {24'b0, DEF_TX});
    check("post_rst_underruns", underruns, 32'd1);
    check("post_rst_rx", {24'b0, q_at(rx_seen, 0)}, 32'h12);

    // ---- table-driven single-byte frames ----
    for (int i = 0; i < 5; i++) begin
      load_buf(vecs[i].tx);
      check("vec_ready_low", {31'b0, tx_ready}, 32'd0);
      rx_seen.delete();
      underruns = 0;
      mo = {vecs[i].mo};
      spi_frame(mo, 8, mi);
      check("vec_miso", {24'b0, q_at(mi, 0)}, {24'b0, vecs[i].exp_miso});
      check("vec_rx_count", rx_seen.size(), 32'd1);
      check("vec_rx_data", {24'b0, q_at(rx_seen, 0)}, {24'b0, vecs[i].exp_rx});
      check("vec_underruns", underruns, 32'd0);
      check("vec_ready_high", {31'b0, tx_ready}, 32'd1);
      check("vec_idle_busy", {31'b0, busy}, 32'd0);
      check("vec_idle_miso", {31'b0, miso}, {31'b0, IDLE_MISO});
    end

    // ---- back-to-back bytes streamed through valid/ready ----
    tx_q = {8'h01, 8'h02, 8'h03};
    feed_en = 1'b1;
    wait_clks(4);
    rx_seen.delete();
    underruns = 0;
    mo = {8'hDE, 8'hAD, 8'hBE};
    spi_frame(mo, 8, mi);
    for (int i = 0; i < 3; i++) begin
      check("b2b_miso", {24'b0, q_at(mi, i)}, i + 1);
      check("b2b_rx", {24'b0, q_at(rx_seen, i)}, {24'b0, mo[i]});
    end
    check("b2b_rx_count", rx_seen.size(), 32'd3);
    check("b2b_underruns", underruns, 32'd0);
    wait_clks(2);
    feed_en = 1'b0;

    // ---- underrun with a byte offered in the LOAD cycle ----
    check("col_ready", {31'b0, tx_ready}, 32'd1);
    rx_seen.delete();
    underruns = 0;
    seen_busy = 1'b0;
    mo = {8'h11, 8'h22};
    fork
      spi_frame(mo, 8, mi);
      begin
        for (int c = 0; c < 20 && !seen_busy; c++) begin
          @(negedge clk);
          if (busy) seen_busy = 1'b1;
        end
        if (seen_busy) load_buf(8'h5A);
      end
    join
    check("col_busy_seen", {31'b0, seen_busy}, 32'd1);
    check("col_byte1_default", {24'b0, q_at(mi, 0)}, {24'b0, DEF_TX});
    check("col_byte2", {24'b0, q_at(mi, 1)}, 32'h5A);
    check("col_underruns", underruns, 32'd1);
    check("col_rx_count", rx_seen.size(), 32'd2);

    // ---- abort after 5 bits, then a clean frame ----
    rx_seen.delete();
    mo = {8'hF0};
    spi_frame(mo, 5, mi);
    check("abort_no_rx", rx_seen.size(), 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    mo = {8'hC3};
    spi_frame(mo, 8, mi);
    check("abort_next_count", rx_seen.size(), 32'd1);
    check("abort_next_rx", {24'b0, q_at(rx_seen, 0)}, 32'hC3);

    // ---- randomized frames against the FIFO-level model ----
    feed_en = 1'b1;
    model_q.delete();
    for (int it = 0; it < 12; it++) begin
      n = int'($urandom_range(1, 4));
      k = int'($urandom_range(0, n));
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        tx_q.push_back(b);
        model_q.push_back(b);
      end
      wait_clks(4);
      abort_f   = ($urandom_range(0, 3) == 0);
      last_bits = abort_f ? int'($urandom_range(1, 7)) : 8;
      mo = {};
      for (int j = 0; j < n; j++) mo.push_back(8'($urandom));
      rx_seen.delete();
      underruns = 0;
      exp_ur = 0;
      spi_frame(mo, last_bits, mi);
      for (int j = 0; j < n; j++) begin
        if (model_q.size() > 0) e = model_q.pop_front();
        else begin
          e = DEF_TX;
          exp_ur++;
        end
        if (j < n - 1 || !abort_f) begin
          check("rnd_miso", {24'b0, q_at(mi, j)}, {24'b0, e});
          check("rnd_rx", {24'b0, q_at(rx_seen, j)}, {24'b0, mo[j]});
        end
      end
      check("rnd_rx_count", rx_seen.size(), abort_f ? n - 1 : n);
      check("rnd_underruns", underruns, exp_ur);
      check("rnd_busy", {31'b0, busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
